// File: rtl/cache_control.sv
// Controller for an 8-set, direct-mapped, write-back, write-allocate cache.
// Owns the tag/valid/dirty state and sequences hits, write-backs and line fills.
module cache_control #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        mem_address,
  input  logic [31:0]        mem_byte_enable,
  input  logic [255:0]       mem_wdata,
  output logic [255:0]       mem_rdata,
  output logic               mem_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [31:0]        pmem_address,
  output logic [255:0]       pmem_wdata,
  input  logic [255:0]       pmem_rdata,
  input  logic               pmem_resp,
  output logic [31:0]        data_write_en,
  output logic [S_INDEX-1:0] data_rindex,
  output logic [S_INDEX-1:0] data_windex,
  output logic [255:0]       data_datain,
  input  logic [255:0]       data_dataout,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
);
  localparam int NUM_SETS = 1 << S_INDEX;

  typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;

  state_t            state_reg;
  logic              filled_reg;
  logic [31:0]       hit_count_reg;
  logic [31:0]       miss_count_reg;

  logic [S_TAG-1:0]    set_tag [NUM_SETS];
  logic [NUM_SETS-1:0] set_valid;
  logic [NUM_SETS-1:0] set_dirty;

  logic [S_TAG-1:0]   req_tag;
  logic [S_INDEX-1:0] index;
  logic               hit;
  logic               write_hit;
  logic               wb_done;
  logic               fill_done;
  logic               unused_offset;

  assign req_tag       = mem_address[31 -: S_TAG];
  assign index         = mem_address[S_OFFSET +: S_INDEX];
  assign unused_offset = ^mem_address[S_OFFSET-1:0];

  assign hit       = set_valid[index] && (set_tag[index] == req_tag);
  assign write_hit = (state_reg == CHECK) && hit && mem_write;
  assign wb_done   = (state_reg == WB) && pmem_resp;
  assign fill_done = (state_reg == FILL) && pmem_resp;

  generate
    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
      logic [S_TAG-1:0] tag_reg;
      logic             valid_reg;
      logic             dirty_reg;
      logic             sel;

      assign sel = (index == S_INDEX'(gi));

      always_ff @(posedge clk) begin
        if (!rst) begin
          tag_reg   <= '0;
          valid_reg <= 1'b0;
          dirty_reg <= 1'b0;
        end else if (sel) begin
          if (fill_done) begin
            tag_reg   <= req_tag;
            valid_reg <= 1'b1;
            dirty_reg <= 1'b0;
          end else if (wb_done) begin
            dirty_reg <= 1'b0;
          end else if (write_hit) begin
            dirty_reg <= |mem_byte_enable;
          end
        end
      end

      assign set_tag[gi]   = tag_reg;
      assign set_valid[gi] = valid_reg;
      assign set_dirty[gi] = dirty_reg;
    end
  endgenerate

  // filled_reg marks the CHECK that closes an allocation, so it is not also counted as a hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      filled_reg     <= 1'b0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          filled_reg <= 1'b0;
          if (mem_read || mem_write) state_reg <= CHECK;
        end
        CHECK: begin
          if (hit) begin
            if (!filled_reg && (hit_count_reg != 32'hFFFF_FFFF))
              hit_count_reg <= hit_count_reg + 32'd1;
            filled_reg <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            if (miss_count_reg != 32'hFFFF_FFFF)
              miss_count_reg <= miss_count_reg + 32'd1;
            state_reg <= set_dirty[index] ? WB : FILL;
          end
        end
        WB: begin
          if (pmem_resp) state_reg <= FILL;
        end
        FILL: begin
          if (pmem_resp) begin
            filled_reg <= 1'b1;
            state_reg  <= CHECK;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_resp      = (state_reg == CHECK) && hit;
    pmem_write    = (state_reg == WB);
    pmem_read     = (state_reg == FILL);
    pmem_address  = {req_tag, index, {S_OFFSET{1'b0}}};
    data_write_en = '0;
    data_datain   = mem_wdata;
    if (state_reg == WB) pmem_address = {set_tag[index], index, {S_OFFSET{1'b0}}};
    if (write_hit) data_write_en = mem_byte_enable;
    if (fill_done) begin
      data_write_en = '1;
      data_datain   = pmem_rdata;
    end
  end

  assign mem_rdata   = data_dataout;
  assign pmem_wdata  = data_dataout;
  assign data_rindex = index;
  assign data_windex = index;
  assign hit_count   = hit_count_reg;
  assign miss_count  = miss_count_reg;

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Controller for the 8-set, 256-bit-line, byte-write-enabled cache data array.
- Holds the tag, valid and dirty state for all 8 sets.
- Sequences hit, write-back and allocate operations between a single CPU-side requester and line-wide physical memory.
- Drives the data array's write_en, rindex, windex and datain.
- Direct-mapped, write-back, write-allocate.

Parameters:
- S_OFFSET, 5, byte-offset bits (32-byte line)
- S_INDEX, 3, index bits (8 sets); only the default is supported
- S_TAG, 24, tag bits (32 - S_OFFSET - S_INDEX)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- mem_read  in  1  CPU line read request
- mem_write  in  1  CPU line write request
- mem_address  in  32  CPU byte address
- mem_byte_enable  in  32  per-byte write enable for writes
- mem_wdata  in  256  CPU write data, line aligned
- mem_rdata  out  256  read data, valid when mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  memory line fill request
- pmem_write  out  1  memory line write-back request
- pmem_address  out  32  line address, low 5 bits always 0
- pmem_wdata  out  256  write-back data
- pmem_rdata  in  256  fill data, valid with pmem_resp
- pmem_resp  in  1  memory completion pulse
- data_write_en  out  32  to data array write_en
- data_rindex  out  3  to data array rindex
- data_windex  out  3  to data array windex
- data_datain  out  256  to data array datain
- data_dataout  in  256  from data array dataout
- hit_count  out  32  saturating hit counter
- miss_count  out  32  saturating miss counter

Behaviour:
- Address split: tag = addr[31:8], index = addr[7:5], offset = addr[4:0]; offset is ignored.
- Handshake: the requester holds mem_read/mem_write, address, byte_enable and wdata stable until the cycle mem_resp=1. It may drop or change the request the following cycle.
- Simultaneous mem_read and mem_write is illegal; if it occurs, the write takes priority.
- data_rindex = data_windex = mem_address index at all times.
- data_write_en = 0 except where stated below.
- mem_rdata = data_dataout combinationally.
- pmem_wdata = data_dataout combinationally.
- Reset (rst=0 at posedge):
  - state goes to IDLE; all valid and dirty bits clear; tags clear; hit_count and miss_count go to 0.
  - mem_resp, pmem_read, pmem_write and data_write_en are 0 from the next cycle.
  - A reset during WB or FILL abandons the operation; a pmem_resp arriving after reset is ignored.
- States and transitions:
  - IDLE: if mem_read or mem_write -> CHECK; otherwise stay.
  - CHECK: hit = valid[index] & (tag[index] == req tag).
    - Read hit: mem_resp=1 this cycle; hit_count++; -> IDLE.
    - Write hit: data_write_en = mem_byte_enable; data_datain = mem_wdata; mem_resp=1; dirty[index] <= |mem_byte_enable; hit_count++; -> IDLE.
    - Miss and dirty: miss_count++; -> WB.
    - Miss and clean: miss_count++; -> FILL.
  - WB: pmem_write=1; pmem_address = {tag[index], index, 5'b0}. On pmem_resp: dirty[index] <= 0; -> FILL.
  - FILL: pmem_read=1; pmem_address = {req tag, index, 5'b0}. On pmem_resp:
    - data_write_en = all ones; data_datain = pmem_rdata;
    - tag[index] <= req tag; valid <= 1; dirty <= 0;
    - -> CHECK, which then completes as a hit without incrementing hit_count.
- pmem_read and pmem_write are registered-state decodes: never both high, and they remain high until the cycle pmem_resp=1 inclusive.
- pmem_resp in IDLE or CHECK is ignored.
- Latency:
  - Hit: mem_resp 2 cycles after the request is first sampled.
  - Clean miss: 2 + fill cycles + 1.
  - Dirty miss: additionally includes the write-back cycles.
- Counters saturate at 32'hFFFF_FFFF with no wrap.
- An allocation is counted once in miss_count only.

Test Plan:
- Reset with rst=0, then read 0x0000_0040 -> FILL at pmem_address 0x0000_0040. pmem_rdata=0xAA..AA with resp -> data_write_en=0xFFFF_FFFF, then mem_resp with mem_rdata=0xAA..AA; miss_count=1, hit_count=0.
- Repeat the read of 0x0000_0040 -> mem_resp 2 cycles after the request, no pmem activity; hit_count=1.
- Write 0x0000_0044 with byte_enable=0x0000_000F and wdata low word 0x1234_5678 -> data_write_en=0x0000_000F, mem_resp. Subsequent read returns low word 0x1234_5678, upper bytes 0xAA.
- Read 0x0000_1040 (same index 2, new tag) -> WB first with pmem_address=0x0000_0040 and pmem_wdata holding the written line. Then FILL at 0x0000_1040, then mem_resp; miss_count=2.
- Assert rst=0 while in FILL waiting, then pulse pmem_resp after reset -> no array write, pmem_read=0. The next read of 0x0000_0040 misses because valid was cleared.
- Preload miss_count to 32'hFFFF_FFFF via forced state, then take a miss -> count stays 32'hFFFF_FFFF.
